instr_boot_loader: RTL and testbench

- Sits directly upstream of the single-cycle CPU datapath.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory write port, holding the CPU in reset until the image is loaded.
- Releases the CPU on success; keeps it in reset on error.

---
 rtl/instr_boot_loader.sv | 169 ++++++++++++++++
 tb/tb_instr_boot_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_boot_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_boot_loader : byte-stream to instruction-memory loader, holds CPU in reset
// until the image is written. Optional macro BOOT_CHECKSUM_EN adds a checksum byte.
// Revision 1.0
// ---------------------------------------------------------------------------
module instr_boot_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  clock,
   input  logic                  Reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  reload,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   localparam logic [16:0] c_max_words = 17'(MAX_WORDS);
`ifdef BOOT_CHECKSUM_EN
   localparam state_t c_end_state = S_CHECK;
`else
   localparam state_t c_end_state = S_DONE;
`endif

   state_t                r_state;
   state_t                w_state_next;
   logic [7:0]            r_len_hi;
   logic [15:0]           r_len;
   logic [1:0]            r_byte_cnt;
   logic [23:0]           r_word_buf;
   logic [ADDR_WIDTH-1:0] r_word_idx;
   logic [ADDR_WIDTH:0]   r_words_loaded;
   logic                  r_imem_we;
   logic [ADDR_WIDTH-1:0] r_imem_addr;
   logic [31:0]           r_imem_wdata;
   logic                  r_done;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]            r_sum;
   logic [7:0]            w_sum_next;
`endif

   logic                  w_accept;
   logic                  w_reload_ok;
   logic [15:0]           w_len_full;
   logic                  w_last_word;

   assign in_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                         (r_state == S_DATA)   || (r_state == S_CHECK);
   assign w_accept     = in_valid && in_ready;
   assign w_reload_ok  = reload && ((r_state == S_DONE) || (r_state == S_ERROR));
   assign w_len_full   = {r_len_hi, in_data};
   assign w_last_word  = ((17'(r_words_loaded) + 17'd1) == {1'b0, r_len});
`ifdef BOOT_CHECKSUM_EN
   assign w_sum_next   = r_sum + in_data;
`endif

   assign imem_we      = r_imem_we;
   assign imem_addr    = r_imem_addr;
   assign imem_wdata   = r_imem_wdata;
   assign words_loaded = r_words_loaded;
   assign done         = r_done;
   assign error        = (r_state == S_ERROR);
   // done lags the state by one cycle so the CPU leaves reset only after the last write
   assign cpu_reset    = ~r_done;

   always_ff @(posedge clock) begin
      if (Reset) r_state <= S_LEN_HI;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_LEN_HI: if (w_accept) w_state_next = S_LEN_LO;
         S_LEN_LO: begin
            if (w_accept) begin
               if ({1'b0, w_len_full} > c_max_words) w_state_next = S_ERROR;
               else if (w_len_full == 16'd0)          w_state_next = c_end_state;
               else                                   w_state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (w_accept && (r_byte_cnt == 2'd3) && w_last_word) w_state_next = c_end_state;
         end
`ifdef BOOT_CHECKSUM_EN
         S_CHECK: begin
            if (w_accept) w_state_next = (w_sum_next == 8'd0) ? S_DONE : S_ERROR;
         end
`else
         S_CHECK: w_state_next = S_LEN_HI;
`endif
         S_DONE, S_ERROR: if (reload) w_state_next = S_LEN_HI;
         default: w_state_next = S_LEN_HI;
      endcase
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         r_len_hi       <= '0;
         r_len          <= '0;
         r_byte_cnt     <= '0;
         r_word_buf     <= '0;
         r_word_idx     <= '0;
         r_words_loaded <= '0;
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= '0;
         r_done         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         r_sum          <= '0;
`endif
      end else begin
         r_imem_we <= 1'b0;
         r_done    <= (r_state == S_DONE) && !reload;
         if (w_reload_ok) begin
            r_byte_cnt     <= '0;
            r_word_idx     <= '0;
            r_words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum          <= '0;
`endif
         end
         if (w_accept) begin
`ifdef BOOT_CHECKSUM_EN
            if (r_state != S_CHECK) r_sum <= w_sum_next;
`endif
            case (r_state)
               S_LEN_HI: r_len_hi <= in_data;
               S_LEN_LO: r_len    <= w_len_full;
               S_DATA: begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  case (r_byte_cnt)
                     2'd0: r_word_buf[23:16] <= in_data;
                     2'd1: r_word_buf[15:8]  <= in_data;
                     2'd2: r_word_buf[7:0]   <= in_data;
                     default: begin
                        r_imem_we      <= 1'b1;
                        r_imem_addr    <= r_word_idx;
                        r_imem_wdata   <= {r_word_buf, in_data};
                        r_word_idx     <= r_word_idx + 1'b1;
                        r_words_loaded <= r_words_loaded + 1'b1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_boot_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_boot_loader : directed frames with a write scoreboard for instr_boot_loader.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_instr_boot_loader;

   logic        clock;
   logic        Reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        reload;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        done;
   logic        error;
   logic [8:0]  words_loaded;

   int total = 0;
   int bad   = 0;
   logic [39:0] sb_q[$];
   logic [7:0]  tb_sum;
   bit          gap;

   instr_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
      .clock(clock), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // write monitor: every imem_we pulse must match the next expected write
   always @(negedge clock) begin
      if (imem_we) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: addr=%h data=%h with nothing expected", imem_addr, imem_wdata);
         end else begin
            logic [39:0] e;
            e = sb_q.pop_front();
            if (imem_addr !== e[39:32] || imem_wdata !== e[31:0]) begin
               bad++;
               $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                        imem_addr, imem_wdata, e[39:32], e[31:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("handshake_timeout", 32'(in_ready), 32'd1);
      end else begin
         tb_sum = tb_sum + b;
         tick();
      end
      in_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic send_word(input logic [7:0] addr, input logic [31:0] w);
      sb_q.push_back({addr, w});
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic end_frame();
`ifdef BOOT_CHECKSUM_EN
      send_byte(8'd0 - tb_sum);
`endif
   endtask

   task automatic do_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
      tb_sum = 8'd0;
   endtask

   initial begin
      Reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
      gap = 1'b0; tb_sum = 8'd0;
      tick(); tick();
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_done",      32'(done),      32'd0);
      Reset = 1'b0;

      // single word image
      send_byte(8'h00); send_byte(8'h01);
      send_word(8'd0, 32'h12345678);
`ifndef BOOT_CHECKSUM_EN
      chk("t1_we_cycle_done",     32'(done),      32'd0);
      chk("t1_we_cycle_cpu_rst",  32'(cpu_reset), 32'd1);
      chk("t1_we_cycle_in_ready", 32'(in_ready),  32'd0);
`endif
      end_frame();
      tick();
      chk("t1_done",      32'(done),         32'd1);
      chk("t1_cpu_reset", 32'(cpu_reset),    32'd0);
      chk("t1_words",     32'(words_loaded), 32'd1);
      chk("t1_in_ready",  32'(in_ready),     32'd0);

      // three words with idle cycles between every byte
      do_reload();
      chk("t2_reload_cpu_reset", 32'(cpu_reset),    32'd1);
      chk("t2_reload_done",      32'(done),         32'd0);
      chk("t2_reload_words",     32'(words_loaded), 32'd0);
      gap = 1'b1;
      send_byte(8'h00); send_byte(8'h03);
      send_word(8'd0, 32'hDEADBEEF);
      send_word(8'd1, 32'h01020304);
      send_word(8'd2, 32'hA5A55A5A);
      end_frame();
      gap = 1'b0;
      tick();
      chk("t2_done",  32'(done),         32'd1);
      chk("t2_words", 32'(words_loaded), 32'd3);

      // oversize image rejected, then in_valid held while not ready
      do_reload();
      send_byte(8'h01); send_byte(8'h01);
      chk("t3_error",     32'(error),     32'd1);
      chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("t3_in_ready",  32'(in_ready),  32'd0);
      in_valid = 1'b1; in_data = 8'hFF;
      tick(); tick(); tick();
      in_valid = 1'b0;
      chk("t3_hold_error", 32'(error),        32'd1);
      chk("t3_hold_words", 32'(words_loaded), 32'd0);
      chk("t3_hold_done",  32'(done),         32'd0);

      // largest accepted image, reload from ERROR
      do_reload();
      chk("t3b_error_clr", 32'(error), 32'd0);
      send_byte(8'h01); send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] a;
         a = 8'(i);
         send_word(a, {a, ~a, a ^ 8'h5A, 8'd255 - a});
      end
      end_frame();
      tick();
      chk("t3b_done",  32'(done),         32'd1);
      chk("t3b_words", 32'(words_loaded), 32'd256);

      // reset (with reload) mid-word, then reload a one-word image
      do_reload();
      send_byte(8'h00); send_byte(8'h02);
      send_word(8'd0, 32'h11223344);
      send_byte(8'h55); send_byte(8'h66);
      Reset = 1'b1; reload = 1'b1;
      tick();
      Reset = 1'b0; reload = 1'b0; tb_sum = 8'd0;
      chk("t4_in_ready",  32'(in_ready),     32'd1);
      chk("t4_we",        32'(imem_we),      32'd0);
      chk("t4_addr",      32'(imem_addr),    32'd0);
      chk("t4_wdata",     imem_wdata,        32'd0);
      chk("t4_cpu_reset", 32'(cpu_reset),    32'd1);
      chk("t4_done",      32'(done),         32'd0);
      chk("t4_error",     32'(error),        32'd0);
      chk("t4_words",     32'(words_loaded), 32'd0);
      send_byte(8'h00); send_byte(8'h01);
      send_word(8'd0, 32'hAABBCCDD);
      end_frame();
      tick();
      chk("t4_done_after", 32'(done), 32'd1);

      // empty image after reload
      do_reload();
      chk("t5_reload_cpu_reset", 32'(cpu_reset), 32'd1);
      send_byte(8'h00); send_byte(8'h00);
`ifndef BOOT_CHECKSUM_EN
      chk("t5_lag_done", 32'(done), 32'd0);
`endif
      end_frame();
      tick();
      chk("t5_done",      32'(done),         32'd1);
      chk("t5_cpu_reset", 32'(cpu_reset),    32'd0);
      chk("t5_words",     32'(words_loaded), 32'd0);

`ifdef BOOT_CHECKSUM_EN
      // 00+01+12+34+56+78 = 0x15 mod 256, so 0xEB closes the sum and 0xEC does not
      do_reload();
      send_byte(8'h00); send_byte(8'h01);
      send_word(8'd0, 32'h12345678);
      send_byte(8'hEB);
      tick();
      chk("t6_good_done", 32'(done), 32'd1);
      do_reload();
      send_byte(8'h00); send_byte(8'h01);
      send_word(8'd0, 32'h12345678);
      send_byte(8'hEC);
      tick();
      chk("t6_bad_error",     32'(error),     32'd1);
      chk("t6_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

      tick(); tick();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
